// File: rtl/game_pkg.sv
// Shared definitions for the line-clear path of the falling-block game.
// Contents: default playfield size, sequencer state type, the score
// increment table and a helper that turns a row index into the LSB
// position of that row in a flattened ROWS*COLS occupancy vector.
package game_pkg;

  localparam int DEF_ROWS = 20;
  localparam int DEF_COLS = 12;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FLASH,
    COLLAPSE,
    DONE
  } state_t;

  // Points awarded for k simultaneously cleared lines.
  function automatic logic [3:0] score_for_lines(input logic [4:0] k);
    logic [3:0] s;
    case (k)
      5'd0:    s = 4'd0;
      5'd1:    s = 4'd1;
      5'd2:    s = 4'd3;
      5'd3:    s = 4'd5;
      default: s = 4'd8;
    endcase
    return s;
  endfunction

  // Bit r*cols+c holds row r, column c; this returns the LSB of row r.
  function automatic int row_lsb(input int row, input int cols);
    return row * cols;
  endfunction

endpackage

// File: rtl/line_clear_flash_timer.sv
// Blink timer for the flash phase of a line clear.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   en        - high while the sequencer is flashing; low re-arms the timer
//   phase     - 1 for the lit half-period, 0 for the dark one; starts at 1
//   finished  - one-cycle pulse during the last cycle of the last half-period
module line_clear_flash_timer #(
  parameter int FLASH_PERIOD = 12_500_000,
  parameter int FLASH_BLINKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase,
  output logic finished
);

  localparam int CW     = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int HALVES = 2 * FLASH_BLINKS;
  localparam int HW     = (HALVES > 1) ? $clog2(HALVES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FLASH_PERIOD - 1);
  localparam logic [HW-1:0] LAST   = HW'(HALVES - 1);

  logic [CW-1:0] cnt;
  logic [HW-1:0] half_cnt;
  logic          tc;

  assign tc       = (cnt == '0);
  assign finished = en && tc && (half_cnt == LAST);

  // Holding the timer in its armed state while disabled guarantees every
  // flash sequence begins with a full lit half-period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt      <= RELOAD;
      half_cnt <= '0;
      phase    <= 1'b1;
    end else if (tc) begin
      cnt      <= RELOAD;
      half_cnt <= half_cnt + HW'(1);
      phase    <= ~phase;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// Row-clear sequencer: snapshots the playfield after a piece locks, finds
// full rows, blinks them on the flash plane, collapses the survivors
// downward and writes the result back with a one-cycle strobe.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   start          - one-cycle lock pulse; matrix_in is sampled with it
//   matrix_in      - occupancy snapshot, bit r*COLS+c = row r, col c
//   matrix_out     - collapsed playfield, valid with matrix_we, then held
//   matrix_we      - one-cycle write strobe
//   flash_out      - flash plane, same layout as matrix_in
//   busy           - high while an operation is in progress
//   done           - one-cycle completion pulse (with matrix_we)
//   lines_cleared  - number of full rows found, held until next start
//   score_inc      - score increment for those rows, held likewise
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// SCAN     | one row per cycle builds full_mask, then one decision cycle
// FLASH    | full rows blink on flash_out under the blink timer
// COLLAPSE | survivors copied bottom-up into new_mat, full rows skipped
// DONE     | result presented with matrix_we/done for one cycle
module line_clear_sequencer
  import game_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int FLASH_PERIOD = 12_500_000,
  parameter int FLASH_BLINKS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] matrix_in,
  output logic [ROWS*COLS-1:0] matrix_out,
  output logic                 matrix_we,
  output logic [ROWS*COLS-1:0] flash_out,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           lines_cleared,
  output logic [3:0]           score_inc
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(ROWS + 1);  // row_idx must reach ROWS
  localparam int PW = $clog2(ROWS) + 1;  // signed, one step below zero

  state_t state, state_nxt;

  logic [N-1:0]           work;
  logic [N-1:0]           new_mat;
  logic [ROWS-1:0]        full_mask;
  logic [IW-1:0]          row_idx;
  logic signed [PW-1:0]   src, dst;
  logic [PW-2:0]          src_u, dst_u;

  logic            phase, flash_fin;
  logic            scan_end, row_full;
  logic            src_valid, src_full, coll_write, coll_last;
  logic [COLS-1:0] coll_row;
  logic [4:0]      k_lines;

  line_clear_flash_timer #(
    .FLASH_PERIOD (FLASH_PERIOD),
    .FLASH_BLINKS (FLASH_BLINKS)
  ) u_flash_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (state == FLASH),
    .phase    (phase),
    .finished (flash_fin)
  );

  assign scan_end   = (row_idx == IW'(ROWS));
  assign row_full   = &work[row_lsb(int'(row_idx), COLS) +: COLS];
  assign k_lines    = 5'($countones(full_mask));

  // Once src runs past the top row the remaining destinations are filled
  // with empty rows.
  assign src_u      = src[PW-2:0];
  assign dst_u      = dst[PW-2:0];
  assign src_valid  = ~src[PW-1];
  assign src_full   = src_valid && full_mask[src_u];
  assign coll_write = ~src_full;
  assign coll_last  = coll_write && (dst == '0);
  assign coll_row   = src_valid ? work[row_lsb(int'(src_u), COLS) +: COLS] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)     state_nxt = SCAN;
      SCAN:     if (scan_end)  state_nxt = (full_mask == '0) ? DONE : FLASH;
      FLASH:    if (flash_fin) state_nxt = COLLAPSE;
      COLLAPSE: if (coll_last) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    matrix_we = (state == DONE);
    flash_out = '0;
    for (int r = 0; r < ROWS; r++) begin
      flash_out[row_lsb(r, COLS) +: COLS] =
        {COLS{(state == FLASH) && phase && full_mask[r]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work          <= '0;
      new_mat       <= '0;
      full_mask     <= '0;
      row_idx       <= '0;
      src           <= '0;
      dst           <= '0;
      matrix_out    <= '0;
      lines_cleared <= '0;
      score_inc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work          <= matrix_in;
            full_mask     <= '0;
            row_idx       <= '0;
            matrix_out    <= '0;
            lines_cleared <= '0;
            score_inc     <= '0;
          end
        end
        SCAN: begin
          if (!scan_end) begin
            full_mask[row_idx] <= row_full;
            row_idx            <= row_idx + IW'(1);
          end else if (full_mask == '0) begin
            matrix_out <= work;
          end
        end
        FLASH: begin
          if (flash_fin) begin
            src     <= PW'(ROWS - 1);
            dst     <= PW'(ROWS - 1);
            new_mat <= '0;
          end
        end
        COLLAPSE: begin
          if (src_valid) src <= src - PW'(1);
          if (coll_write) begin
            new_mat[row_lsb(int'(dst_u), COLS) +: COLS] <= coll_row;
            dst <= dst - PW'(1);
          end
          // The final write always lands in row 0, so the result can be
          // published on the same edge without waiting for new_mat.
          if (coll_last) begin
            matrix_out    <= {new_mat[N-1:COLS], coll_row};
            lines_cleared <= k_lines;
            score_inc     <= score_for_lines(k_lines);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_sequencer.sv
module tb_line_clear_sequencer;

  localparam int ROWS = 20;
  localparam int COLS = 12;
  localparam int FP   = 4;
  localparam int FB   = 2;
  localparam int N    = ROWS * COLS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] matrix_in;
  logic [N-1:0] matrix_out;
  logic         matrix_we;
  logic [N-1:0] flash_out;
  logic         busy;
  logic         done;
  logic [4:0]   lines_cleared;
  logic [3:0]   score_inc;

  always #5 clk = ~clk;

  line_clear_sequencer #(
    .ROWS (ROWS), .COLS (COLS), .FLASH_PERIOD (FP), .FLASH_BLINKS (FB)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .matrix_in (matrix_in),
    .matrix_out (matrix_out), .matrix_we (matrix_we), .flash_out (flash_out),
    .busy (busy), .done (done), .lines_cleared (lines_cleared),
    .score_inc (score_inc)
  );

  int n_vec = 0;
  int n_err = 0;

  // observations filled by run_op
  int           done_at, done_cnt, we_bad;
  logic [N-1:0] got_mat, got_mat_end;
  logic [4:0]   got_lines, lines_at1;
  logic [3:0]   got_score;
  logic         busy_end;
  logic [N-1:0] flash_q[$];

  // ---------------- reference model ----------------
  function automatic int model_k(input logic [N-1:0] m);
    int k = 0;
    for (int r = 0; r < ROWS; r++) if (&m[r*COLS +: COLS]) k++;
    return k;
  endfunction

  function automatic logic [N-1:0] model_collapse(input logic [N-1:0] m);
    logic [COLS-1:0] kept[$];
    logic [N-1:0] res = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (!(&m[r*COLS +: COLS])) kept.push_back(m[r*COLS +: COLS]);
    for (int i = 0; i < kept.size(); i++) res[(ROWS-1-i)*COLS +: COLS] = kept[i];
    return res;
  endfunction

  function automatic int model_score(input int k);
    if (k >= 4) return 8;
    return (k == 0) ? 0 : 2 * k - 1;
  endfunction

  // edges after the start edge at which done is visible
  function automatic int model_done_at(input int k);
    if (k == 0) return ROWS + 1;
    return (ROWS + 1) + 2 * FB * FP + ROWS + k;
  endfunction

  // flash plane seen just after edge n following the start edge
  function automatic logic [N-1:0] model_flash(input logic [N-1:0] m, input int n);
    logic [N-1:0] f = '0;
    int t;
    if (model_k(m) == 0) return f;
    t = n - (ROWS + 1);
    if (t < 0 || t >= 2 * FB * FP) return f;
    if (((t / FP) % 2) != 0) return f;
    for (int r = 0; r < ROWS; r++) if (&m[r*COLS +: COLS]) f[r*COLS +: COLS] = '1;
    return f;
  endfunction

  function automatic logic [N-1:0] with_row(input logic [N-1:0] m, input int r,
                                            input logic [COLS-1:0] v);
    m[r*COLS +: COLS] = v;
    return m;
  endfunction

  function automatic logic [N-1:0] rand_matrix();
    logic [N-1:0] m = '0;
    for (int r = 0; r < ROWS; r++)
      m[r*COLS +: COLS] = ($urandom_range(0, 2) == 0) ? '1 : COLS'($urandom);
    return m;
  endfunction

  // Applies one start and records what the DUT did; bounded by 250 cycles.
  task automatic run_op(input logic [N-1:0] m, input int extra_start_at);
    flash_q.delete();
    done_at = -1; done_cnt = 0; we_bad = 0;
    @(negedge clk);
    matrix_in = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    matrix_in = rand_matrix();  // snapshot must not follow the input
    for (int n = 1; n <= 250; n++) begin
      if (n == extra_start_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 1) lines_at1 = lines_cleared;
      flash_q.push_back(flash_out);
      if (matrix_we !== done) we_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at   = n;
          got_mat   = matrix_out;
        end
      end
      if (done_at >= 0 && n >= done_at + 3) break;
    end
    got_mat_end = matrix_out;
    got_lines   = lines_cleared;
    got_score   = score_inc;
    busy_end    = busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; matrix_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0 || matrix_we !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got done=%b we=%b want 0", done, matrix_we); end
    n_vec++; if (matrix_out !== '0 || flash_out !== '0) begin n_err++; $display("FAIL reset_planes: got nonzero matrix_out/flash_out want 0"); end
    n_vec++; if (lines_cleared !== 5'd0 || score_inc !== 4'd0) begin n_err++; $display("FAIL reset_counts: got lines=%0d score=%0d want 0", lines_cleared, score_inc); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_run(input string name, input logic [N-1:0] m);
    int k = model_k(m);
    int flash_bad = 0;
    foreach (flash_q[i]) if (flash_q[i] !== model_flash(m, i + 1)) flash_bad++;
    n_vec++; if (done_at !== model_done_at(k)) begin n_err++; $display("FAIL %s_done_at: got %0d want %0d", name, done_at, model_done_at(k)); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); end
    n_vec++; if (got_mat !== model_collapse(m)) begin n_err++; $display("FAIL %s_matrix: got %h want %h", name, got_mat, model_collapse(m)); end
    n_vec++; if (got_mat_end !== model_collapse(m)) begin n_err++; $display("FAIL %s_matrix_held: got %h want %h", name, got_mat_end, model_collapse(m)); end
    n_vec++; if (got_lines !== 5'(k)) begin n_err++; $display("FAIL %s_lines: got %0d want %0d", name, got_lines, k); end
    n_vec++; if (got_score !== 4'(model_score(k))) begin n_err++; $display("FAIL %s_score: got %0d want %0d", name, got_score, model_score(k)); end
    n_vec++; if (flash_bad !== 0) begin n_err++; $display("FAIL %s_flash: got %0d bad cycles want 0", name, flash_bad); end
    n_vec++; if (we_bad !== 0 || busy_end !== 1'b0) begin n_err++; $display("FAIL %s_strobe_busy: got we_bad=%0d busy=%b want 0/0", name, we_bad, busy_end); end
  endtask

  task automatic test_no_clear();
    logic [N-1:0] m = with_row('0, 19, 12'h7FF);
    run_op(m, 0);
    check_run("no_clear", m);
  endtask

  task automatic test_single_line();
    logic [N-1:0] m = with_row(with_row('0, 19, 12'hFFF), 18, 12'h00F);
    run_op(m, 0);
    check_run("single", m);
    n_vec++; if (got_mat !== with_row('0, 19, 12'h00F)) begin n_err++; $display("FAIL single_literal: got %h", got_mat); end
  endtask

  task automatic test_four_lines();
    logic [N-1:0] m = '0;
    m = with_row(m, 14, 12'hFFF); m = with_row(m, 15, 12'hFFF);
    m = with_row(m, 17, 12'hFFF); m = with_row(m, 19, 12'hFFF);
    m = with_row(m, 16, 12'h801); m = with_row(m, 18, 12'h0F0);
    run_op(m, 0);
    check_run("four", m);
    n_vec++; if (got_mat !== with_row(with_row('0, 19, 12'h0F0), 18, 12'h801)) begin n_err++; $display("FAIL four_literal: got %h", got_mat); end
    n_vec++; if (lines_at1 !== 5'd0) begin n_err++; $display("FAIL four_lines_cleared_at_start: got %0d want 0", lines_at1); end
  endtask

  task automatic test_all_full();
    logic [N-1:0] m = '1;
    run_op(m, 30);  // second start lands mid-FLASH
    check_run("all_full", m);
  endtask

  task automatic test_rst_mid_flash();
    logic [N-1:0] m = with_row(with_row('0, 19, 12'hFFF), 18, 12'h00F);
    @(negedge clk);
    matrix_in = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    n_vec++; if (flash_out !== with_row('0, 19, 12'hFFF)) begin n_err++; $display("FAIL rst_pre_flash: got %h", flash_out); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (flash_out !== '0) begin n_err++; $display("FAIL rst_flash_off: got %h want 0", flash_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (matrix_we !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_no_write: got we=%b done=%b want 0", matrix_we, done); end
    run_op(m, 0);
    check_run("after_rst", m);
  endtask

  task automatic test_start_rst_same();
    int busy_seen = 0;
    int done_seen = 0;
    @(negedge clk);
    matrix_in = with_row('0, 19, 12'hFFF); start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (busy !== 1'b0) busy_seen++;
      if (done !== 1'b0) done_seen++;
      @(posedge clk); #1;
    end
    n_vec++; if (busy_seen !== 0) begin n_err++; $display("FAIL start_rst_busy: got %0d busy cycles want 0", busy_seen); end
    n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL start_rst_done: got %0d done cycles want 0", done_seen); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [N-1:0] m = rand_matrix();
      int extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : 0;
      run_op(m, extra);
      check_run($sformatf("random%0d", it), m);
    end
  endtask

  task automatic test_reset_clears();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (lines_cleared !== 5'd0 || score_inc !== 4'd0 || matrix_out !== '0) begin n_err++; $display("FAIL reset_clears: got lines=%0d score=%0d want 0 and zero matrix", lines_cleared, score_inc); end
  endtask

  initial begin
    test_reset();
    test_no_clear();
    test_single_line();
    test_four_lines();
    test_all_full();
    test_rst_mid_flash();
    test_start_rst_same();
    test_random();
    test_single_line();
    test_reset_clears();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
